// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: MUL* results after a fixed latency,
// DIV/REM via a radix-2 restoring divider, one op in flight.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ROB_IDX_W  = 4,
  parameter int MUL_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rdy,
  input  logic                 rollback_config,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_a,
  input  logic [XLEN-1:0]      in_b,
  input  logic [ROB_IDX_W-1:0] in_rob_entry,
  output logic                 out_config,
  output logic [XLEN-1:0]      out_val,
  output logic [ROB_IDX_W-1:0] out_rob_entry
);

  localparam int CMAX =
    (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
  localparam int CW = $clog2(CMAX) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t                 state;
  logic [2:0]             f3;
  logic [ROB_IDX_W-1:0]   tag;
  logic [XLEN-1:0]        op_a;
  logic [XLEN-1:0]        op_b;
  logic [XLEN-1:0]        quo;
  logic [XLEN-1:0]        rem;
  logic [XLEN-1:0]        dvs;
  logic                   neg_q;
  logic                   neg_r;
  logic                   spec;
  logic [CW-1:0]          cnt;

  logic                   accept;
  logic                   sgn_div;
  logic                   a_neg;
  logic                   b_neg;
  logic [XLEN-1:0]        a_abs;
  logic [XLEN-1:0]        b_abs;
  logic                   div_zero;
  logic                   div_ovf;
  logic [XLEN-1:0]        spec_val;
  logic [2*XLEN-1:0]      ma;
  logic [2*XLEN-1:0]      mb;
  logic [2*XLEN-1:0]      prod;
  logic [XLEN:0]          r_sh;
  logic [XLEN:0]          diff;
  logic                   ge;
  logic [XLEN-1:0]        q_fix;
  logic [XLEN-1:0]        r_fix;
  logic [XLEN-1:0]        result;

  assign in_ready = (state == S_IDLE)
                  & ~rollback_config;
  assign accept = rdy & in_valid & in_ready;

  // Issue-side divide prep: magnitudes, signs, special cases
  always_comb begin
    sgn_div  = ~in_funct3[0];
    a_neg    = sgn_div & in_a[XLEN-1];
    b_neg    = sgn_div & in_b[XLEN-1];
    a_abs    = a_neg ? -in_a : in_a;
    b_abs    = b_neg ? -in_b : in_b;
    div_zero = (in_b == '0);
    div_ovf  = sgn_div
             & (in_a == {1'b1, {(XLEN-1){1'b0}}})
             & (&in_b);
    spec_val = '0;
    if (div_zero)
      spec_val = in_funct3[1] ? in_a : '1;
    else
      spec_val = in_funct3[1] ? '0 : in_a;
  end

  // Full-width product; sign-extend per MULH variant
  always_comb begin
    ma = {{XLEN{(f3[1:0] != 2'b11) & op_a[XLEN-1]}},
          op_a};
    mb = {{XLEN{(f3[1:0] == 2'b01) & op_b[XLEN-1]}},
          op_b};
    prod = ma * mb;
  end

  // One restoring-division step
  always_comb begin
    r_sh = {rem, quo[XLEN-1]};
    diff = r_sh - {1'b0, dvs};
    ge   = ~diff[XLEN];
  end

  // Final result selection with sign fix-up
  always_comb begin
    q_fix  = neg_q ? -quo : quo;
    r_fix  = neg_r ? -rem : rem;
    result = '0;
    unique case (1'b1)
      ~f3[2] & (f3[1:0] == 2'b00):
        result = prod[XLEN-1:0];
      ~f3[2] & (f3[1:0] != 2'b00):
        result = prod[2*XLEN-1:XLEN];
      f3[2] & spec:
        result = quo;
      f3[2] & ~spec & f3[1]:
        result = r_fix;
      f3[2] & ~spec & ~f3[1]:
        result = q_fix;
      default:
        result = '0;
    endcase
  end

  // Control FSM, datapath registers and result pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      f3            <= '0;
      tag           <= '0;
      op_a          <= '0;
      op_b          <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs           <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      spec          <= 1'b0;
      cnt           <= '0;
      out_config    <= 1'b0;
      out_val       <= '0;
      out_rob_entry <= '0;
    end else if (rdy) begin
      out_config <= 1'b0;
      if (rollback_config) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (accept) begin
              f3   <= in_funct3;
              tag  <= in_rob_entry;
              op_a <= in_a;
              op_b <= in_b;
              cnt  <= '0;
              if (!in_funct3[2]) begin
                state <= (MUL_STAGES > 1)
                       ? S_MUL : S_DONE;
              end else if (div_zero | div_ovf) begin
                quo   <= spec_val;
                spec  <= 1'b1;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                state <= S_DONE;
              end else begin
                quo   <= a_abs;
                rem   <= '0;
                dvs   <= b_abs;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                spec  <= 1'b0;
                state <= S_DIV;
              end
            end
          end
          S_MUL: begin
            cnt <= cnt + 1'b1;
            if (int'(cnt) == MUL_STAGES - 2)
              state <= S_DONE;
          end
          S_DIV: begin
            quo <= {quo[XLEN-2:0], ge};
            rem <= ge ? diff[XLEN-1:0]
                      : r_sh[XLEN-1:0];
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1))
              state <= S_DONE;
          end
          S_DONE: begin
            out_config    <= 1'b1;
            out_val       <= result;
            out_rob_entry <= tag;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Checks values, tags, latency, stall, flush and reset.
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        rollback_config;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_rob_entry;
  logic        out_config;
  logic [31:0] out_val;
  logic [3:0]  out_rob_entry;

  int nvec;
  int nbad;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  muldiv_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rdy             (rdy),
    .rollback_config (rollback_config),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_funct3       (in_funct3),
    .in_a            (in_a),
    .in_b            (in_b),
    .in_rob_entry    (in_rob_entry),
    .out_config      (out_config),
    .out_val         (out_val),
    .out_rob_entry   (out_rob_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for its pulse, check it.
  // stall_at>0: rdy low for 5 edges after that
  // cycle. poke: hammer in_valid while busy.
  task automatic run(
    input string       nm,
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [3:0]  tg,
    input logic [31:0] exp,
    input int          lat,
    input int          stall_at,
    input bit          poke
  );
    int k;
    int viol;
    in_valid     = 1'b1;
    in_funct3    = f;
    in_a         = a;
    in_b         = b;
    in_rob_entry = tg;
    tick();
    in_valid = 1'b0;
    k    = 0;
    viol = 0;
    do begin
      if (in_ready) viol++;
      tick();
      k++;
      if (k == stall_at) rdy = 1'b0;
      if (stall_at > 0 && k == stall_at + 5)
        rdy = 1'b1;
      if (poke && k == 3) begin
        in_valid     = 1'b1;
        in_funct3    = F_MUL;
        in_a         = 32'd3;
        in_rob_entry = tg ^ 4'hF;
      end
      if (poke && k == 10) in_valid = 1'b0;
    end while (!out_config && k < 200);
    chk({nm, "_lat"}, 32'(k), 32'(lat));
    chk({nm, "_val"}, out_val, exp);
    chk({nm, "_tag"}, 32'(out_rob_entry),
        32'(tg));
    chk({nm, "_busy"}, 32'(viol), 32'd0);
    chk({nm, "_b2b"}, 32'(in_ready), 32'd1);
    tick();
    chk({nm, "_pulse"}, 32'(out_config), 32'd0);
  endtask

  task automatic quiet(input string nm);
    int n;
    n = 0;
    repeat (40) begin
      tick();
      if (out_config) n++;
    end
    chk(nm, 32'(n), 32'd0);
  endtask

  initial begin
    nvec            = 0;
    nbad            = 0;
    rst_n           = 1'b0;
    rdy             = 1'b1;
    rollback_config = 1'b0;
    in_valid        = 1'b0;
    in_funct3       = '0;
    in_a            = '0;
    in_b            = '0;
    in_rob_entry    = '0;
    repeat (3) tick();
    chk("rst_cfg", 32'(out_config), 32'd0);
    chk("rst_val", out_val, 32'd0);
    chk("rst_tag", 32'(out_rob_entry), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    run("mul", F_MUL, 32'd7, 32'hFFFFFFFD,
        4'd3, 32'hFFFFFFEB, 2, 0, 0);
    run("mul2", F_MUL, 32'h12345678, 32'h10,
        4'd4, 32'h23456780, 2, 0, 0);
    run("mulh", F_MULH, 32'h80000000,
        32'h80000000, 4'd5, 32'h40000000,
        2, 0, 0);
    run("mulhu", F_MULHU, 32'h80000000,
        32'h80000000, 4'd6, 32'h40000000,
        2, 0, 0);
    run("mulhu2", F_MULHU, 32'hFFFFFFFF,
        32'hFFFFFFFF, 4'd7, 32'hFFFFFFFE,
        2, 0, 0);
    run("mulhsu", F_MULHSU, 32'hFFFFFFFF,
        32'hFFFFFFFF, 4'd8, 32'hFFFFFFFF,
        2, 0, 0);

    run("div", F_DIV, 32'hFFFFFFEC, 32'd3,
        4'd9, 32'hFFFFFFFA, 33, 0, 1);
    run("rem", F_REM, 32'hFFFFFFEC, 32'd3,
        4'd10, 32'hFFFFFFFE, 33, 0, 0);
    run("divu", F_DIVU, 32'd20, 32'd3,
        4'd11, 32'd6, 33, 0, 0);
    run("remu", F_REMU, 32'd20, 32'd3,
        4'd12, 32'd2, 33, 0, 0);
    run("div_nd", F_DIV, 32'd20, 32'hFFFFFFFD,
        4'd13, 32'hFFFFFFFA, 33, 0, 0);
    run("rem_nd", F_REM, 32'd20, 32'hFFFFFFFD,
        4'd14, 32'd2, 33, 0, 0);

    run("div0", F_DIV, 32'd5, 32'd0,
        4'd1, 32'hFFFFFFFF, 1, 0, 0);
    run("rem0", F_REM, 32'd5, 32'd0,
        4'd2, 32'd5, 1, 0, 0);
    run("divu0", F_DIVU, 32'd5, 32'd0,
        4'd3, 32'hFFFFFFFF, 1, 0, 0);
    run("remu0", F_REMU, 32'd5, 32'd0,
        4'd4, 32'd5, 1, 0, 0);
    run("divovf", F_DIV, 32'h80000000,
        32'hFFFFFFFF, 4'd5, 32'h80000000,
        1, 0, 0);
    run("removf", F_REM, 32'h80000000,
        32'hFFFFFFFF, 4'd6, 32'd0, 1, 0, 0);

    // Flush a divide at iteration 10
    in_valid     = 1'b1;
    in_funct3    = F_DIV;
    in_a         = 32'd1000;
    in_b         = 32'd7;
    in_rob_entry = 4'd5;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    rollback_config = 1'b1;
    #1;
    chk("rb_rdy_lo", 32'(in_ready), 32'd0);
    tick();
    rollback_config = 1'b0;
    #1;
    chk("rb_rdy_hi", 32'(in_ready), 32'd1);
    run("rb_mul", F_MUL, 32'd9, 32'd11,
        4'd9, 32'd99, 2, 0, 0);
    quiet("rb_nopulse");

    // rdy low for 5 edges mid-divide
    run("stall", F_DIVU, 32'd1000, 32'd7,
        4'd2, 32'd142, 38, 10, 0);

    // Async reset mid-divide
    in_valid     = 1'b1;
    in_funct3    = F_DIV;
    in_a         = 32'd77;
    in_b         = 32'd5;
    in_rob_entry = 4'd7;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_cfg", 32'(out_config), 32'd0);
    chk("ar_val", out_val, 32'd0);
    chk("ar_tag", 32'(out_rob_entry), 32'd0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("ar_rdy", 32'(in_ready), 32'd1);
    quiet("ar_nopulse");

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
